// File: rtl/ksa_pipe_adder.sv
// ksa_pipe_adder
//   Gate-level-pipelined Kogge-Stone adder for pulse-encoded operands.
//   Each operand bit arrives as a pulse; a set-latch per bit remembers that
//   the pulse happened during the current GCLK period. The capture edge turns
//   the latches into a clocked operation, which then walks through a PG stage,
//   LVLS = clog2(WIDTH) prefix stages and a sum stage. One operation can be
//   issued every GCLK period; nothing ever stalls.
//
// Ports
//   GCLK_Pad   in   1      global clock, all pipeline registers on rising edge
//   RSTN_Pad   in   1      asynchronous active-low reset
//   a_Pad      in   WIDTH  operand A, one pulse per 1 bit
//   b_Pad      in   WIDTH  operand B, one pulse per 1 bit
//   cin_Pad    in   1      carry-in pulse
//   vld_Pad    in   1      operand-valid pulse
//   sum_Pad    out  WIDTH  registered sum, gated by ovld_Pad
//   cout_Pad   out  1      registered carry-out, gated by ovld_Pad
//   ovf_Pad    out  1      registered two's-complement overflow, gated by ovld_Pad
//   ovld_Pad   out  1      result-valid, one period per issued operation
//   err_Pad    out  1      operand pulses seen in a period without vld_Pad
//
// Valid semantics: an operation is issued in the period where the vld_Pad
// latch is set; it is accepted unconditionally (there is no ready), and its
// result is presented for exactly one period with ovld_Pad high, LVLS+2 edges
// after the capture edge. Outputs are 0 whenever ovld_Pad is 0.

module ksa_pipe_adder #(
   parameter int WIDTH = 4
) (
   input  logic             GCLK_Pad,
   input  logic             RSTN_Pad,
   input  logic [WIDTH-1:0] a_Pad,
   input  logic [WIDTH-1:0] b_Pad,
   input  logic             cin_Pad,
   input  logic             vld_Pad,
   output logic [WIDTH-1:0] sum_Pad,
   output logic             cout_Pad,
   output logic             ovf_Pad,
   output logic             ovld_Pad,
   output logic             err_Pad
);

   localparam int LVLS = $clog2(WIDTH);
   localparam int NP   = 2 * WIDTH + 2;
   localparam logic [WIDTH-1:0] ONES = '1;

   // ---------------------------------------------------------------------
   // Capture stage: pulse set-latches.
   // Each latch is a toggle flop clocked by its own pad plus a GCLK-domain
   // copy ("seen"). The latch reads as set while tog != seen. A pad pulse
   // toggles only while the latch reads clear, so repeated pulses within
   // one period still count as a single 1. The capture edge clears every
   // latch by copying tog into seen.
   // ---------------------------------------------------------------------
   logic [NP-1:0] pad_v;
   logic [NP-1:0] pad_tog;
   logic [NP-1:0] pad_seen;
   logic [NP-1:0] pad_set;

   assign pad_v   = {vld_Pad, cin_Pad, b_Pad, a_Pad};
   assign pad_set = pad_tog ^ pad_seen;

   for (genvar i = 0; i < NP; i++) begin : g_latch
      logic tog;
      always_ff @(posedge pad_v[i] or negedge RSTN_Pad) begin
         if (!RSTN_Pad)
            tog <= 1'b0;
         else if (tog == pad_seen[i])
            tog <= ~tog;
      end
      assign pad_tog[i] = tog;
   end

   logic [WIDTH-1:0] cap_a;
   logic [WIDTH-1:0] cap_b;
   logic             cap_cin;
   logic             cap_vld;

   always_ff @(posedge GCLK_Pad or negedge RSTN_Pad) begin
      if (!RSTN_Pad) begin
         pad_seen <= '0;
         cap_a    <= '0;
         cap_b    <= '0;
         cap_cin  <= 1'b0;
         cap_vld  <= 1'b0;
         err_Pad  <= 1'b0;
      end else begin
         pad_seen <= pad_tog;
         cap_vld  <= pad_set[NP-1];
         // Without vld the period becomes a bubble: data is dropped to 0.
         if (pad_set[NP-1]) begin
            cap_a   <= pad_set[WIDTH-1:0];
            cap_b   <= pad_set[2*WIDTH-1:WIDTH];
            cap_cin <= pad_set[2*WIDTH];
         end else begin
            cap_a   <= '0;
            cap_b   <= '0;
            cap_cin <= 1'b0;
         end
         err_Pad <= ~pad_set[NP-1] & (|pad_set[NP-2:0]);
      end
   end

   // ---------------------------------------------------------------------
   // PG, prefix and sum stages.
   // Index l of g_q/p_q is the group generate/propagate after prefix level l
   // (l = 0 is the PG stage). The top-level P is never consumed, so p_q
   // stops one level short. pd_q carries the bitwise propagate down to the
   // sum stage; c_q/v_q carry cin and valid alongside the data.
   // ---------------------------------------------------------------------
   logic [LVLS:0][WIDTH-1:0]   g_q;
   logic [LVLS-1:0][WIDTH-1:0] p_q;
   logic [LVLS:1][WIDTH-1:0]   pd_q;
   logic [LVLS:0]              c_q;
   logic [LVLS:0]              v_q;
   logic [WIDTH-1:0]           pg_p;
   logic [WIDTH-1:0]           pg_g;
   logic [WIDTH:0]             carry;

   // Carry-in is folded into bit 0 so the prefix tree needs no extra column.
   always_comb begin
      pg_p    = cap_a ^ cap_b;
      pg_g    = cap_a & cap_b;
      pg_g[0] = pg_g[0] | (pg_p[0] & cap_cin);
   end

   // carry[i] is the carry into bit i; carry[WIDTH] is the carry-out.
   assign carry = {g_q[LVLS], c_q[LVLS]};

   always_ff @(posedge GCLK_Pad or negedge RSTN_Pad) begin
      if (!RSTN_Pad) begin
         g_q      <= '0;
         p_q      <= '0;
         pd_q     <= '0;
         c_q      <= '0;
         v_q      <= '0;
         sum_Pad  <= '0;
         cout_Pad <= 1'b0;
         ovf_Pad  <= 1'b0;
         ovld_Pad <= 1'b0;
      end else begin
         g_q[0] <= pg_g;
         p_q[0] <= pg_p;
         c_q[0] <= cap_cin;
         v_q[0] <= cap_vld;

         // Level l combines node i with node i - 2^(l-1). Nodes below the
         // span pass through: shifting in zeros for G and ones for P makes
         // the same expression act as a balancing register for them.
         for (int l = 1; l <= LVLS; l++) begin
            g_q[l] <= g_q[l-1] | (p_q[l-1] & (g_q[l-1] << (1 << (l-1))));
            c_q[l] <= c_q[l-1];
            v_q[l] <= v_q[l-1];
         end
         for (int l = 1; l < LVLS; l++) begin
            p_q[l] <= p_q[l-1] &
                      ((p_q[l-1] << (1 << (l-1))) | (ONES >> (WIDTH - (1 << (l-1)))));
         end
         pd_q[1] <= p_q[0];
         for (int l = 2; l <= LVLS; l++) begin
            pd_q[l] <= pd_q[l-1];
         end

         // Sum stage: results are only ever non-zero together with ovld.
         ovld_Pad <= v_q[LVLS];
         if (v_q[LVLS]) begin
            sum_Pad  <= pd_q[LVLS] ^ carry[WIDTH-1:0];
            cout_Pad <= carry[WIDTH];
            ovf_Pad  <= carry[WIDTH] ^ carry[WIDTH-1];
         end else begin
            sum_Pad  <= '0;
            cout_Pad <= 1'b0;
            ovf_Pad  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ksa_pipe_adder.sv
// tb_ksa_pipe_adder
//   Drives a WIDTH=4 and a WIDTH=8 instance side by side with pulse-encoded
//   operands. A reference model computes each result with plain integer
//   arithmetic and queues it for the cycle it must appear on the outputs.

module tb_ksa_pipe_adder;

   localparam int LAT4 = 4;   // capture edge to output edge, WIDTH=4
   localparam int LAT8 = 5;   // capture edge to output edge, WIDTH=8

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [3:0] a4 = '0, b4 = '0;
   logic       c4 = 1'b0, v4 = 1'b0;
   logic [3:0] sum4;
   logic       cout4, ovf4, ovld4, err4;

   logic [7:0] a8 = '0, b8 = '0;
   logic       c8 = 1'b0, v8 = 1'b0;
   logic [7:0] sum8;
   logic       cout8, ovf8, ovld8, err8;

   ksa_pipe_adder #(.WIDTH(4)) u_dut4 (
      .GCLK_Pad(clk), .RSTN_Pad(rst_n),
      .a_Pad(a4), .b_Pad(b4), .cin_Pad(c4), .vld_Pad(v4),
      .sum_Pad(sum4), .cout_Pad(cout4), .ovf_Pad(ovf4),
      .ovld_Pad(ovld4), .err_Pad(err4)
   );

   ksa_pipe_adder #(.WIDTH(8)) u_dut8 (
      .GCLK_Pad(clk), .RSTN_Pad(rst_n),
      .a_Pad(a8), .b_Pad(b8), .cin_Pad(c8), .vld_Pad(v8),
      .sum_Pad(sum8), .cout_Pad(cout8), .ovf_Pad(ovf8),
      .ovld_Pad(ovld8), .err_Pad(err8)
   );

   // ---------------- checking ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: {ovld, cout, ovf, sum} for a w-bit add, from integer math.
   function automatic logic [63:0] ref_add(input int w, input longint a, input longint b,
                                           input longint c);
      longint s, sa, sb, ss, lim;
      logic   ovf;
      lim = longint'(1) << (w - 1);
      s   = a + b + c;
      sa  = (a >= lim) ? a - 2 * lim : a;
      sb  = (b >= lim) ? b - 2 * lim : b;
      ss  = sa + sb + c;
      ovf = (ss >= lim) || (ss < -lim);
      return (s & ((lim << 1) - 1)) | (longint'(ovf) << w) |
             (((s >> w) & 1) << (w + 1)) | (longint'(1) << (w + 2));
   endfunction

   // What was pulsed in the current period (written only by the driver).
   logic [3:0] pa4 = '0, pb4 = '0;
   logic       pc4 = 1'b0, pv4 = 1'b0;
   logic [7:0] pa8 = '0, pb8 = '0;
   logic       pc8 = 1'b0, pv8 = 1'b0;

   // ---------------- driver ----------------
   // One call per GCLK period: pulses land mid-period, well away from edges.
   task automatic drive(input logic [3:0] ia4, input logic [3:0] ib4, input logic ic4,
                        input logic iv4, input logic [7:0] ia8, input logic [7:0] ib8,
                        input logic ic8, input logic iv8, input bit dbl);
      @(negedge clk);
      #1;
      if (rst_n) begin
         pa4 = ia4; pb4 = ib4; pc4 = ic4; pv4 = iv4;
         pa8 = ia8; pb8 = ib8; pc8 = ic8; pv8 = iv8;
      end else begin
         pa4 = '0; pb4 = '0; pc4 = 1'b0; pv4 = 1'b0;
         pa8 = '0; pb8 = '0; pc8 = 1'b0; pv8 = 1'b0;
      end
      for (int k = 0; k < (dbl ? 2 : 1); k++) begin
         a4 = ia4; b4 = ib4; c4 = ic4; v4 = iv4;
         a8 = ia8; b8 = ib8; c8 = ic8; v8 = iv8;
         #1;
         a4 = '0; b4 = '0; c4 = 1'b0; v4 = 1'b0;
         a8 = '0; b8 = '0; c8 = 1'b0; v8 = 1'b0;
         if (dbl && k == 0) #1;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive('0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   // ---------------- scoreboard ----------------
   logic [6:0]  exp_q4[$];
   logic [10:0] exp_q8[$];

   initial begin
      logic [6:0]  e4;
      logic [10:0] e8;
      logic        ee4, ee8;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            // Everything in flight is lost; refill with empty slots.
            exp_q4.delete();
            exp_q8.delete();
            repeat (LAT4) exp_q4.push_back('0);
            repeat (LAT8) exp_q8.push_back('0);
            exp_q4.push_back('0);
            exp_q8.push_back('0);
            ee4 = 1'b0;
            ee8 = 1'b0;
         end else begin
            exp_q4.push_back(pv4 ? 7'(ref_add(4, longint'(pa4), longint'(pb4), longint'(pc4)))
                                 : 7'd0);
            exp_q8.push_back(pv8 ? 11'(ref_add(8, longint'(pa8), longint'(pb8), longint'(pc8)))
                                 : 11'd0);
            ee4 = !pv4 && (pa4 != 0 || pb4 != 0 || pc4);
            ee8 = !pv8 && (pa8 != 0 || pb8 != 0 || pc8);
         end
         #1;
         e4 = exp_q4.pop_front();
         e8 = exp_q8.pop_front();
         check("sum4",  64'(sum4),  64'(e4[3:0]));
         check("ovf4",  64'(ovf4),  64'(e4[4]));
         check("cout4", 64'(cout4), 64'(e4[5]));
         check("ovld4", 64'(ovld4), 64'(e4[6]));
         check("err4",  64'(err4),  64'(ee4));
         check("sum8",  64'(sum8),  64'(e8[7:0]));
         check("ovf8",  64'(ovf8),  64'(e8[8]));
         check("cout8", 64'(cout8), 64'(e8[9]));
         check("ovld8", 64'(ovld8), 64'(e8[10]));
         check("err8",  64'(err8),  64'(ee8));
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      exp_q4.delete();
      exp_q8.delete();
      idle(3);
      #1 rst_n = 1'b1;
      idle(20);

      // Directed: wrap with carry, overflow, back-to-back issue.
      drive(4'd3,  4'd14, 1'b1, 1'b1, 8'd255, 8'd0, 1'b1, 1'b1, 1'b0);
      drive(4'd10, 4'd12, 1'b1, 1'b1, 8'd127, 8'd1, 1'b0, 1'b1, 1'b0);
      drive(4'd1,  4'd0,  1'b0, 1'b1, 8'd128, 8'd128, 1'b0, 1'b1, 1'b1);
      // Operand pulses without vld: error, no result.
      drive(4'b0001, 4'b0100, 1'b0, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0);
      idle(6);

      // Reset mid-operation: three in flight, first one on the outputs.
      drive(4'd7, 4'd9, 1'b0, 1'b1, 8'd200, 8'd100, 1'b0, 1'b1, 1'b0);
      drive(4'd2, 4'd2, 1'b1, 1'b1, 8'd1,   8'd2,   1'b1, 1'b1, 1'b0);
      drive(4'd8, 4'd8, 1'b0, 1'b1, 8'd64,  8'd64,  1'b0, 1'b1, 1'b0);
      idle(2);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("rst_sum4",  64'(sum4),  64'd0);
      check("rst_ovld4", 64'(ovld4), 64'd0);
      check("rst_cout4", 64'(cout4), 64'd0);
      check("rst_sum8",  64'(sum8),  64'd0);
      check("rst_ovld8", 64'(ovld8), 64'd0);
      idle(1);
      // Pulses during reset are ignored, even when released before the edge.
      drive(4'd6, 4'd6, 1'b1, 1'b1, 8'd6, 8'd6, 1'b1, 1'b1, 1'b0);
      #1 rst_n = 1'b1;
      drive(4'd5, 4'd5, 1'b0, 1'b1, 8'd127, 8'd127, 1'b1, 1'b1, 1'b0);
      idle(8);

      // Randomized traffic, including bubbles, error periods and double pulses.
      for (int i = 0; i < 400; i++) begin
         drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0),
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0),
               ($urandom_range(0, 3) == 0));
      end
      idle(8);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ksa_pipe_adder.md
# ksa_pipe_adder

Parametrised, gate-level-pipelined Kogge-Stone adder for the SFQ/pulse-logic flow. It generalises the fixed 4-bit pulse-input adder to any power-of-two WIDTH. It adds an explicit operand-valid pulse, pipelined result-valid, signed-overflow and protocol-error outputs, and full back-to-back issue (one operation per GCLK period). It sits between pulse-encoded operand sources and downstream clocked pulse consumers, and is the building block for wider datapath adders.

## Interface
- WIDTH, 4, operand/sum width; power of two, 2..64
- LVLS, clog2(WIDTH), derived; number of prefix levels (not overridable)
- GCLK_Pad  in  1  global clock; all pipeline registers update on rising edge
- RSTN_Pad  in  1  reset; asynchronous, active-low
- a_Pad  in  WIDTH  operand A bits, pulse-encoded (rising edge = logic 1 for current cycle)
- b_Pad  in  WIDTH  operand B bits, pulse-encoded
- cin_Pad  in  1  carry-in, pulse-encoded
- vld_Pad  in  1  operand-valid pulse; marks that an operation is issued this cycle
- sum_Pad  out  WIDTH  sum bits, registered, high for one GCLK period per 1 bit
- cout_Pad  out  1  carry-out, registered
- ovf_Pad  out  1  two's-complement overflow, registered
- ovld_Pad  out  1  result-valid, high for one GCLK period
- err_Pad  out  1  protocol error, high for one GCLK period

## Operation
- Capture stage: one set-latch per a/b/cin/vld bit. The latch sets on the rising edge of its pad. GCLK edge k samples all latches into capture registers and clears them. Multiple pulses on one bit in one period count as a single 1.
- Cycle k with vld latch = 0: the operand is discarded and the pipeline advances with a bubble (valid=0, data=0). If any a/b/cin latch was set in that cycle, err_Pad pulses on the following edge.
- PG stage: p_i = a_i ^ b_i, g_i = a_i & b_i; carry-in is folded in as g_-1 = cin at bit 0.
- Prefix levels l = 1..LVLS, one register stage each, span 2^(l-1). G = G_hi | (P_hi & G_lo), P = P_hi & P_lo. Pass-through nodes are DFF-balanced, so every path has equal depth.
- Sum stage: sum_i = p_i ^ c_i, cout = c_WIDTH, ovf = c_WIDTH ^ c_(WIDTH-1).
- The valid bit travels alongside data. sum/cout/ovf are forced to 0 when valid = 0. Outputs are never 1 without ovld_Pad.
- The pipeline has no stall and no backpressure. Every stage advances every edge.

## Timing
- Latency: operand pulses arrive in the period before capture edge E. Results appear on outputs after edge E+LVLS+2 and are held for exactly one period. For WIDTH=4, that is 4 edges after capture.
- Throughput: 1 operation per GCLK period. Consecutive issues produce consecutive ovld_Pad periods.
- Pulses must lie at least 10 ps from a GCLK rising edge. A pulse coincident with an edge is undefined, and the bench avoids it.
- Reset (RSTN_Pad low, asynchronous): all latches, stages and outputs go to 0 immediately. sum_Pad=0, cout_Pad=0, ovf_Pad=0, ovld_Pad=0, err_Pad=0.
- Reset mid-operation: in-flight operations are lost with no output pulse. The first valid result after release comes from the first post-release issue, at full latency.
- Pulses arriving while RSTN_Pad is low are ignored.
- Wrap-around: sum is modulo 2^WIDTH, and carry is reported on cout_Pad.

## Test plan
- WIDTH=4, reset then idle for 20 cycles -> all outputs 0 throughout.
- WIDTH=4, issue a=3, b=14, cin=1 with vld -> 4 edges later: sum=2, cout=1, ovf=0, ovld=1 for one period.
- WIDTH=4, issue a=10, b=12, cin=1 -> sum=7, cout=1, ovf=1. Then issue a=1, b=0, cin=0 on the next cycle -> sum=1, cout=0, ovf=0 on the very next period.
- WIDTH=4, pulse a0 and b2 without vld -> err_Pad for one period after the next edge, and no ovld_Pad ever for that cycle.
- WIDTH=4, issue 3 back-to-back ops, then pull RSTN_Pad low after 2 edges -> outputs 0 at once, no stale results. A post-release issue of a=5, b=5 -> sum=10, ovf=1 at full latency.
- WIDTH=8, issue a=255, b=0, cin=1 -> after 5 edges: sum=0, cout=1, ovf=0. Also issue a=127, b=1 -> sum=128, ovf=1.
